instr_decode_pipe: RTL and testbench
====================================

// Module: instr_decode_pipe
// PURPOSE
//   Parametrised MIPS ID stage: internal register file, decode, branch/jump
//   resolution, load-use hazard detection and a valid/ready ID/EX register.
//   Sits between IF/ID and EX. Back-pressure and bubble insertion replace the
//   old i_stall/i_halt. Branches resolve in ID and redirect IF in the same cycle.
// PARAMETERS
//   NB_DATA    32            datapath width (>=32, instruction is bits [31:0])
//   NB_REGS    32            register count; NB_ADDR = $clog2(NB_REGS)
//   HALT_WORD  32'hFFFFFFFF  end-of-program instruction
// PORTS
//   clk           in   1        single clock, rising edge
//   i_rst_n       in   1        reset, asynchronous, active-low
//   i_valid       in   1        IF/ID holds a valid instruction
//   o_ready       out  1        ID accepts instruction this cycle
//   i_instruction in   NB_DATA  instruction word
//   i_pc4         in   NB_DATA  PC+4 of the instruction
//   i_wb_we       in   1        WB write enable
//   i_wb_addr     in   NB_ADDR  WB destination
//   i_wb_data     in   NB_DATA  WB data
//   i_ex_memread  in   1        instruction in EX is a load
//   i_ex_rt       in   NB_ADDR  load destination in EX
//   i_ex_ready    in   1        EX accepts ID/EX contents
//   o_valid       out  1        ID/EX holds a valid instruction
//   o_rs/o_rt/o_rd out NB_ADDR  register indices (forwarding keys)
//   o_da, o_db    out  NB_DATA  operand data
//   o_imm         out  NB_DATA  sign/zero-extended immediate
//   o_opcode/o_func/o_shamt out 6/6/5  instruction fields
//   o_ctrl        out  13       {regWrite,mem2Reg,memRead,memWrite,regDst,
//                               immFlag,signFlag,aluSrc[1:0],aluOp[1:0],width[1:0]}
//   o_redirect    out  1        combinational: taken branch/jump this cycle
//   o_target      out  NB_DATA  combinational redirect target
//   o_halted      out  1        HALT_WORD accepted (sticky)
// BEHAVIOUR
//   - Reset: every registered output 0, o_valid=0, o_halted=0, all regs 0.
//   - Regfile: r0 reads 0, ignores writes; write on clk rise; same-cycle WB
//     bypass when i_wb_we && i_wb_addr==rs/rt && addr!=0.
//   - Control from existing control_unit table (combinational use only).
//   - fire = i_valid && o_ready. stall = i_valid && i_ex_memread && i_ex_rt!=0
//     && (i_ex_rt==rs || (i_ex_rt==rt && uses_rt)); uses_rt: R-type, BEQ, BNE,
//     stores (opcode[5:3]==3'b101).
//   - o_ready = !stall && !o_halted && (!o_valid || i_ex_ready).
//   - fire: ID/EX loads all fields, o_valid<=1; latency 1 cycle.
//     else if i_ex_ready: o_valid<=0, o_ctrl<=0 (bubble); else hold all.
//   - o_redirect only on fire. BEQ/BNE: target = pc4 + (sext(imm)<<2),
//     taken on rs==rt / rs!=rt. J/JAL: {pc4[31:28],instr[25:0],2'b00}.
//     JR/JALR (R-type func 8/9): target = bypassed rs data.
//   - Link (JAL, JALR): o_da<=pc4, o_db<=4, o_rs<=0, o_rt<=0, regWrite=1,
//     ALU add; o_rd<=31 for JAL, instr rd for JALR.
//   - HALT_WORD on fire: issues bubble (o_valid<=0), o_halted<=1 until reset;
//     then o_ready=0; ID/EX drains normally.
//   - Stall and WB to same reg in one cycle: bypass applies, stall still wins.
//   - Reset mid-operation clears ID/EX immediately; no redirect after reset.
// CONFIGURATION
//   ID_BRANCH_FWD_EN defined: adds i_ex_regwrite(1), i_ex_rd(NB_ADDR),
//     i_mem_fwd_en(1), i_mem_fwd_addr(NB_ADDR), i_mem_fwd_data(NB_DATA);
//     branch/JR operands take MEM data on address match (nonzero); stall one
//     cycle if EX writes a branch/JR operand.
//   Undefined: none of these ports; branch/JR use regfile+WB bypass only.
// TESTING
//   - Reset, then WB r5=0x1234 while decoding ADD r3,r5,r6 -> o_da=0x1234.
//   - LW r4 in EX, ADD r2,r4,r1 -> o_ready=0 one cycle, bubble o_ctrl=0.
//   - r1=r2=7, BEQ r1,r2,+3 at pc4=0x100 -> o_redirect=1, o_target=0x10C.
//   - JAL 0x40 at pc4=0x20 -> o_target=0x100, o_rd=31, o_da=0x20, o_db=4.
//   - i_ex_ready=0 two cycles with o_valid=1 -> outputs held, o_ready=0.
//   - HALT_WORD -> o_halted=1, o_valid=0 next, o_ready stays 0.

Source files
------------

// File: rtl/instr_decode_pipe.sv
// MIPS ID stage: register file with WB bypass, decode, branch/jump resolution,
// load-use stall and a valid/ready ID/EX register. Optional macro: ID_BRANCH_FWD_EN.
module instr_decode_pipe #(
  parameter int          NB_DATA   = 32,
  parameter int          NB_REGS   = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  localparam int         NB_ADDR   = $clog2(NB_REGS)
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_instruction,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic               i_wb_we,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_memread,
  input  logic [NB_ADDR-1:0] i_ex_rt,
  input  logic               i_ex_ready,
`ifdef ID_BRANCH_FWD_EN
  input  logic               i_ex_regwrite,
  input  logic [NB_ADDR-1:0] i_ex_rd,
  input  logic               i_mem_fwd_en,
  input  logic [NB_ADDR-1:0] i_mem_fwd_addr,
  input  logic [NB_DATA-1:0] i_mem_fwd_data,
`endif
  output logic               o_valid,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [NB_DATA-1:0] o_da,
  output logic [NB_DATA-1:0] o_db,
  output logic [NB_DATA-1:0] o_imm,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_func,
  output logic [4:0]         o_shamt,
  output logic [12:0]        o_ctrl,
  output logic               o_redirect,
  output logic [NB_DATA-1:0] o_target,
  output logic               o_halted
);

  localparam int N_SLOTS = 1 << NB_ADDR;

  logic [5:0]         op, fn;
  logic [4:0]         sh;
  logic [15:0]        imm16;
  logic [NB_ADDR-1:0] rs, rt, rd;

  assign op    = i_instruction[31:26];
  assign fn    = i_instruction[5:0];
  assign sh    = i_instruction[10:6];
  assign imm16 = i_instruction[15:0];
  assign rs    = NB_ADDR'(i_instruction[25:21]);
  assign rt    = NB_ADDR'(i_instruction[20:16]);
  assign rd    = NB_ADDR'(i_instruction[15:11]);

  // Register file: slot 0 and any slot beyond NB_REGS read as zero.
  logic [NB_DATA-1:0] reg_rd [N_SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_reg
      if (gi == 0 || gi >= NB_REGS) begin : g_zero
        assign reg_rd[gi] = '0;
      end else begin : g_live
        logic [NB_DATA-1:0] r_q, r_d;
        always_comb begin
          r_d = r_q;
          if (i_wb_we && i_wb_addr == NB_ADDR'(gi)) r_d = i_wb_data;
        end
        always_ff @(posedge clk or negedge i_rst_n) begin
          if (!i_rst_n) r_q <= '0;
          else          r_q <= r_d;
        end
        assign reg_rd[gi] = r_q;
      end
    end
  endgenerate

  logic [NB_DATA-1:0] rs_data, rt_data;
  assign rs_data = (i_wb_we && i_wb_addr == rs && rs != '0) ? i_wb_data : reg_rd[rs];
  assign rt_data = (i_wb_we && i_wb_addr == rt && rt != '0) ? i_wb_data : reg_rd[rt];

  logic is_rtype, is_jr, is_jalr, is_beq, is_bne, is_j, is_jal, is_halt, uses_rt;
  assign is_rtype = (op == 6'h00);
  assign is_jr    = is_rtype && fn == 6'h08;
  assign is_jalr  = is_rtype && fn == 6'h09;
  assign is_beq   = (op == 6'h04);
  assign is_bne   = (op == 6'h05);
  assign is_j     = (op == 6'h02);
  assign is_jal   = (op == 6'h03);
  assign is_halt  = (i_instruction[31:0] == HALT_WORD);
  assign uses_rt  = is_rtype || is_beq || is_bne || op[5:3] == 3'b101;

  // Control table: aluOp 00=add, 01=sub (branch compare), 10=R-type func, 11=imm op.
  logic       reg_write, mem2reg, mem_read, mem_write, reg_dst, imm_flag, sign_flag;
  logic [1:0] alu_src, alu_op, width;
  logic [12:0] ctrl;

  always_comb begin
    reg_write = 1'b0; mem2reg  = 1'b0; mem_read  = 1'b0; mem_write = 1'b0;
    reg_dst   = 1'b0; imm_flag = 1'b0; sign_flag = 1'b0;
    alu_src   = 2'b00; alu_op  = 2'b00; width    = 2'b00;
    case (op)
      6'h00: begin
        reg_dst   = 1'b1;
        alu_op    = 2'b10;
        reg_write = !is_jr;
        if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) alu_src = 2'b10;
        if (is_jalr) alu_op = 2'b00;
      end
      6'h03: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      6'h04, 6'h05: alu_op = 2'b01;
      6'h08, 6'h09: begin
        reg_write = 1'b1; imm_flag = 1'b1; sign_flag = 1'b1; alu_src = 2'b01;
      end
      6'h0A, 6'h0B: begin
        reg_write = 1'b1; imm_flag = 1'b1; sign_flag = 1'b1; alu_src = 2'b01; alu_op = 2'b11;
      end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        reg_write = 1'b1; imm_flag = 1'b1; alu_src = 2'b01; alu_op = 2'b11;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        reg_write = 1'b1; mem2reg = 1'b1; mem_read = 1'b1;
        imm_flag  = 1'b1; sign_flag = 1'b1; alu_src = 2'b01;
        width     = (op[1:0] == 2'b11) ? 2'b11 : {1'b0, op[0]};
      end
      6'h28, 6'h29, 6'h2B: begin
        mem_write = 1'b1; imm_flag = 1'b1; sign_flag = 1'b1; alu_src = 2'b01;
        width     = (op[1:0] == 2'b11) ? 2'b11 : {1'b0, op[0]};
      end
      default: ;
    endcase
    ctrl = {reg_write, mem2reg, mem_read, mem_write, reg_dst, imm_flag, sign_flag,
            alu_src, alu_op, width};
  end

  logic [NB_DATA-1:0] imm_sext, imm_ext;
  assign imm_sext = {{(NB_DATA-16){imm16[15]}}, imm16};
  assign imm_ext  = sign_flag ? imm_sext : {{(NB_DATA-16){1'b0}}, imm16};

  logic [NB_DATA-1:0] br_a, br_b;
  logic               ex_hazard;
`ifdef ID_BRANCH_FWD_EN
  assign br_a = (i_mem_fwd_en && i_mem_fwd_addr == rs && rs != '0) ? i_mem_fwd_data : rs_data;
  assign br_b = (i_mem_fwd_en && i_mem_fwd_addr == rt && rt != '0) ? i_mem_fwd_data : rt_data;
  // EX result is not yet available to compare in ID, so wait one cycle for it.
  assign ex_hazard = i_valid && i_ex_regwrite && i_ex_rd != '0 &&
                     (((is_beq || is_bne || is_jr || is_jalr) && i_ex_rd == rs) ||
                      ((is_beq || is_bne) && i_ex_rd == rt));
`else
  assign br_a      = rs_data;
  assign br_b      = rt_data;
  assign ex_hazard = 1'b0;
`endif

  logic stall, fire;
  logic valid_q, halted_q;

  assign stall   = (i_valid && i_ex_memread && i_ex_rt != '0 &&
                    (i_ex_rt == rs || (i_ex_rt == rt && uses_rt))) || ex_hazard;
  assign o_ready = !stall && !halted_q && (!valid_q || i_ex_ready);
  assign fire    = i_valid && o_ready;

  logic               take;
  logic [NB_DATA-1:0] tgt;

  always_comb begin
    take = 1'b0;
    tgt  = i_pc4 + {imm_sext[NB_DATA-3:0], 2'b00};
    if (is_beq)                take = (br_a == br_b);
    else if (is_bne)           take = (br_a != br_b);
    else if (is_j || is_jal) begin
      take = 1'b1;
      tgt  = {i_pc4[NB_DATA-1:28], i_instruction[25:0], 2'b00};
    end else if (is_jr || is_jalr) begin
      take = 1'b1;
      tgt  = br_a;
    end
  end

  assign o_redirect = fire && take && !is_halt;
  assign o_target   = tgt;

  logic               valid_d, halted_d;
  logic [NB_ADDR-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [NB_DATA-1:0] da_q, da_d, db_q, db_d, imm_q, imm_d;
  logic [5:0]         opcode_q, opcode_d, func_q, func_d;
  logic [4:0]         shamt_q, shamt_d;
  logic [12:0]        ctrl_q, ctrl_d;

  always_comb begin
    valid_d  = valid_q;  halted_d = halted_q;
    rs_d     = rs_q;     rt_d     = rt_q;     rd_d    = rd_q;
    da_d     = da_q;     db_d     = db_q;     imm_d   = imm_q;
    opcode_d = opcode_q; func_d   = func_q;   shamt_d = shamt_q;
    ctrl_d   = ctrl_q;
    if (fire && is_halt) begin
      valid_d  = 1'b0;
      ctrl_d   = '0;
      halted_d = 1'b1;
    end else if (fire) begin
      valid_d  = 1'b1;
      rs_d     = rs;       rt_d   = rt;      rd_d    = rd;
      da_d     = rs_data;  db_d   = rt_data; imm_d   = imm_ext;
      opcode_d = op;       func_d = fn;      shamt_d = sh;
      ctrl_d   = ctrl;
      // Link: EX computes pc4 + 4 as the return address.
      if (is_jal || is_jalr) begin
        da_d = i_pc4;
        db_d = NB_DATA'(4);
        rs_d = '0;
        rt_d = '0;
        rd_d = is_jal ? NB_ADDR'(31) : rd;
      end
    end else if (i_ex_ready) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0; halted_q <= 1'b0;
      rs_q     <= '0;   rt_q     <= '0;   rd_q    <= '0;
      da_q     <= '0;   db_q     <= '0;   imm_q   <= '0;
      opcode_q <= '0;   func_q   <= '0;   shamt_q <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;  halted_q <= halted_d;
      rs_q     <= rs_d;     rt_q     <= rt_d;     rd_q    <= rd_d;
      da_q     <= da_d;     db_q     <= db_d;     imm_q   <= imm_d;
      opcode_q <= opcode_d; func_q   <= func_d;   shamt_q <= shamt_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_halted = halted_q;
  assign o_rs     = rs_q;
  assign o_rt     = rt_q;
  assign o_rd     = rd_q;
  assign o_da     = da_q;
  assign o_db     = db_q;
  assign o_imm    = imm_q;
  assign o_opcode = opcode_q;
  assign o_func   = func_q;
  assign o_shamt  = shamt_q;
  assign o_ctrl   = ctrl_q;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed-vector bench for instr_decode_pipe (default build, branch forwarding off).
module tb_instr_decode_pipe;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instruction, i_pc4;
  logic        i_wb_we;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ex_memread;
  logic [4:0]  i_ex_rt;
  logic        i_ex_ready;
  logic        o_valid;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [31:0] o_da, o_db, o_imm;
  logic [5:0]  o_opcode, o_func;
  logic [4:0]  o_shamt;
  logic [12:0] o_ctrl;
  logic        o_redirect;
  logic [31:0] o_target;
  logic        o_halted;

  int n_vec = 0;
  int n_err = 0;

  instr_decode_pipe dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instruction(i_instruction), .i_pc4(i_pc4),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_ex_memread(i_ex_memread), .i_ex_rt(i_ex_rt), .i_ex_ready(i_ex_ready),
    .o_valid(o_valid), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_da(o_da), .o_db(o_db), .o_imm(o_imm),
    .o_opcode(o_opcode), .o_func(o_func), .o_shamt(o_shamt), .o_ctrl(o_ctrl),
    .o_redirect(o_redirect), .o_target(o_target), .o_halted(o_halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc4);
    i_valid       = v;
    i_instruction = ins;
    i_pc4         = pc4;
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    i_wb_we   = we;
    i_wb_addr = a;
    i_wb_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD_3_5_6  = 32'h00A6_1820;
  localparam logic [31:0] ADD_2_4_1  = 32'h0081_1020;
  localparam logic [31:0] ADD_3_0_0  = 32'h0000_1820;
  localparam logic [31:0] BEQ_1_2_P3 = 32'h1022_0003;
  localparam logic [31:0] BEQ_1_2_M1 = 32'h1022_FFFF;
  localparam logic [31:0] BNE_1_2_P3 = 32'h1422_0003;
  localparam logic [31:0] JAL_40     = 32'h0C00_0040;
  localparam logic [31:0] JR_7       = 32'h00E0_0008;
  localparam logic [31:0] JALR_9_5   = 32'h00A0_4809;
  localparam logic [31:0] ORI_8_FFFF = 32'h3408_FFFF;
  localparam logic [31:0] ADDI_8_M1  = 32'h2008_FFFF;
  localparam logic [31:0] HALT       = 32'hFFFF_FFFF;

  initial begin
    i_rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    i_ex_memread = 1'b0; i_ex_rt = 5'd0; i_ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  {63'd0, o_valid},  64'd0);
    chk("rst_halted", {63'd0, o_halted}, 64'd0);
    chk("rst_ctrl",   {51'd0, o_ctrl},   64'd0);
    chk("rst_da",     {32'd0, o_da},     64'd0);
    #2 i_rst_n = 1'b1;

    // WB bypass into operand A
    wb(1'b1, 5'd5, 32'h1234);
    drive(1'b1, ADD_3_5_6, 32'h4);
    chk("add_ready", {63'd0, o_ready}, 64'd1);
    tick();
    chk("add_valid", {63'd0, o_valid}, 64'd1);
    chk("add_da",    {32'd0, o_da},    64'h1234);
    chk("add_db",    {32'd0, o_db},    64'h0);
    chk("add_rs",    {59'd0, o_rs},    64'd5);
    chk("add_rt",    {59'd0, o_rt},    64'd6);
    chk("add_rd",    {59'd0, o_rd},    64'd3);
    chk("add_func",  {58'd0, o_func},  64'h20);
    chk("add_ctrl",  {51'd0, o_ctrl},  64'h1108);

    // Preload r1 = r2 = 7 with no instruction in flight
    wb(1'b1, 5'd1, 32'd7);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("idle_valid", {63'd0, o_valid}, 64'd0);
    chk("idle_ctrl",  {51'd0, o_ctrl},  64'd0);
    wb(1'b1, 5'd2, 32'd7);
    tick();

    // Load-use stall, WB to the stalled register in the same cycle
    wb(1'b1, 5'd4, 32'h99);
    i_ex_memread = 1'b1; i_ex_rt = 5'd4;
    drive(1'b1, ADD_2_4_1, 32'h8);
    chk("lu_ready", {63'd0, o_ready}, 64'd0);
    tick();
    chk("lu_bub_valid", {63'd0, o_valid}, 64'd0);
    chk("lu_bub_ctrl",  {51'd0, o_ctrl},  64'd0);
    wb(1'b0, 5'd0, 32'h0);
    i_ex_memread = 1'b0;
    #1;
    chk("lu_ready2", {63'd0, o_ready}, 64'd1);
    tick();
    chk("lu_valid", {63'd0, o_valid}, 64'd1);
    chk("lu_rs",    {59'd0, o_rs},    64'd4);
    chk("lu_da",    {32'd0, o_da},    64'h99);
    chk("lu_db",    {32'd0, o_db},    64'd7);

    // Load in EX writing r0 never stalls
    i_ex_memread = 1'b1; i_ex_rt = 5'd0;
    drive(1'b1, ADD_3_0_0, 32'hC);
    chk("lu_r0_ready", {63'd0, o_ready}, 64'd1);
    i_ex_memread = 1'b0;

    // Branches
    drive(1'b1, BEQ_1_2_P3, 32'h100);
    chk("beq_redir",  {63'd0, o_redirect}, 64'd1);
    chk("beq_target", {32'd0, o_target},   64'h10C);
    tick();
    chk("beq_ctrl", {51'd0, o_ctrl}, 64'h0004);
    chk("beq_imm",  {32'd0, o_imm},  64'h3);
    drive(1'b1, BEQ_1_2_M1, 32'h100);
    chk("beqm_redir",  {63'd0, o_redirect}, 64'd1);
    chk("beqm_target", {32'd0, o_target},   64'hFC);
    tick();
    drive(1'b1, BNE_1_2_P3, 32'h100);
    chk("bne_redir", {63'd0, o_redirect}, 64'd0);
    tick();

    // JAL link
    drive(1'b1, JAL_40, 32'h20);
    chk("jal_redir",  {63'd0, o_redirect}, 64'd1);
    chk("jal_target", {32'd0, o_target},   64'h100);
    tick();
    chk("jal_rd",   {59'd0, o_rd},   64'd31);
    chk("jal_da",   {32'd0, o_da},   64'h20);
    chk("jal_db",   {32'd0, o_db},   64'd4);
    chk("jal_rs",   {59'd0, o_rs},   64'd0);
    chk("jal_ctrl", {51'd0, o_ctrl}, 64'h1100);

    // JR with same-cycle WB bypass on rs
    wb(1'b1, 5'd7, 32'h5678);
    drive(1'b1, JR_7, 32'h200);
    chk("jr_redir",  {63'd0, o_redirect}, 64'd1);
    chk("jr_target", {32'd0, o_target},   64'h5678);
    tick();
    wb(1'b0, 5'd0, 32'h0);

    // JALR rd=9 rs=r5
    drive(1'b1, JALR_9_5, 32'h300);
    chk("jalr_target", {32'd0, o_target}, 64'h1234);
    tick();
    chk("jalr_rd", {59'd0, o_rd}, 64'd9);
    chk("jalr_da", {32'd0, o_da}, 64'h300);
    chk("jalr_db", {32'd0, o_db}, 64'd4);

    // Back-pressure: EX not ready for two cycles, taken branch waiting
    i_ex_ready = 1'b0;
    drive(1'b1, BEQ_1_2_P3, 32'h100);
    chk("bp_ready", {63'd0, o_ready},    64'd0);
    chk("bp_redir", {63'd0, o_redirect}, 64'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bp_hold_valid", {63'd0, o_valid}, 64'd1);
      chk("bp_hold_rd",    {59'd0, o_rd},    64'd9);
      chk("bp_hold_da",    {32'd0, o_da},    64'h300);
      chk("bp_hold_ready", {63'd0, o_ready}, 64'd0);
    end
    i_ex_ready = 1'b1;
    #1;
    chk("bp_rel_ready", {63'd0, o_ready},    64'd1);
    chk("bp_rel_redir", {63'd0, o_redirect}, 64'd1);
    tick();
    chk("bp_rel_ctrl", {51'd0, o_ctrl}, 64'h0004);

    // r0 ignores writes and is never bypassed
    wb(1'b1, 5'd0, 32'hDEAD);
    drive(1'b1, ADD_3_0_0, 32'h10);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("r0_da", {32'd0, o_da}, 64'h0);
    tick();
    chk("r0_da2", {32'd0, o_da}, 64'h0);

    // Immediate extension
    drive(1'b1, ORI_8_FFFF, 32'h14);
    tick();
    chk("ori_imm",  {32'd0, o_imm},  64'h0000FFFF);
    chk("ori_ctrl", {51'd0, o_ctrl}, 64'h109C);
    drive(1'b1, ADDI_8_M1, 32'h18);
    tick();
    chk("addi_imm", {32'd0, o_imm}, 64'hFFFFFFFF);

    // Halt
    drive(1'b1, HALT, 32'h1C);
    chk("halt_ready", {63'd0, o_ready}, 64'd1);
    tick();
    chk("halt_flag",  {63'd0, o_halted}, 64'd1);
    chk("halt_valid", {63'd0, o_valid},  64'd0);
    drive(1'b1, ADD_3_5_6, 32'h20);
    chk("halt_ready2", {63'd0, o_ready}, 64'd0);
    tick();
    chk("halt_valid2", {63'd0, o_valid},  64'd0);
    chk("halt_ready3", {63'd0, o_ready},  64'd0);
    chk("halt_flag2",  {63'd0, o_halted}, 64'd1);

    // Asynchronous reset mid-cycle
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_halted", {63'd0, o_halted}, 64'd0);
    chk("arst_valid",  {63'd0, o_valid},  64'd0);
    #1 i_rst_n = 1'b1;
    drive(1'b1, ADD_3_5_6, 32'h4);
    chk("arst_ready", {63'd0, o_ready}, 64'd1);
    tick();
    chk("arst_da", {32'd0, o_da}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
